fifo_drain_ctrl: RTL and testbench

- Read-side controller for the team's synchronous 8-bit FIFO (64 entries, `buf_empty`/`buf_full`/`fifo_counter`, one-cycle registered read data).
- Pops the FIFO in bursts and presents bytes on a valid/ready stream with an end-of-burst marker.
- Starts a burst when enough data is queued, or when a timeout expires with a partial burst pending.
- A 2-entry skid buffer absorbs the FIFO read latency, giving 1 byte/clk with no loss under backpressure.

---
 rtl/fifo_drain_ctrl.sv | 155 +++++++++++++++
 tb/tb_fifo_drain_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// Read-side burst controller for the 64-entry byte FIFO: pops in bursts and streams the bytes
// on a valid/ready interface through a 2-entry skid buffer that hides the FIFO read latency.
module fifo_drain_ctrl #(
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  buf_out,
  input  logic        buf_empty,
  input  logic [7:0]  fifo_counter,
  output logic        rd_en,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic [15:0] burst_cnt
);

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT);
  localparam logic [7:0]    BurstLen8  = 8'(BURST_LEN);
  localparam logic [6:0]    BurstLen7  = 7'(BURST_LEN);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e        state_q, state_d;
  logic [6:0]    rem_q, rem_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          inflight_q, inflight_d;
  logic          inflight_last_q, inflight_last_d;
  logic [1:0]    occ_q, occ_d;
  logic [7:0]    data0_q, data0_d, data1_q, data1_d;
  logic          last0_q, last0_d, last1_q, last1_d;
  logic          busy_q, busy_d;
  logic [15:0]   burst_cnt_q, burst_cnt_d;

  logic          xfer;
  logic [2:0]    pending;

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = data0_q;
  assign m_last    = last0_q;
  assign busy      = busy_q;
  assign burst_cnt = burst_cnt_q;
  assign xfer      = m_valid && m_ready;

  // Entries that will still be held after this cycle: buffered plus in flight, minus the one
  // leaving now. Keeping this below 2 guarantees a slot for the byte this pop returns.
  assign pending = 3'(occ_q) + 3'(inflight_q) - 3'(xfer);
  assign rd_en   = (state_q == StRead) && !buf_empty && (rem_q != 7'd0) && (pending < 3'd2);

  always_comb begin
    occ_d           = occ_q;
    data0_d         = data0_q;
    last0_d         = last0_q;
    data1_d         = data1_q;
    last1_d         = last1_q;
    inflight_d      = rd_en;
    inflight_last_d = rd_en && (rem_q == 7'd1);
    case ({inflight_q, xfer})
      2'b11: begin
        if (occ_q == 2'd2) begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = buf_out;
          last1_d = inflight_last_q;
        end else begin
          data0_d = buf_out;
          last0_d = inflight_last_q;
        end
      end
      2'b10: begin
        if (occ_q == 2'd0) begin
          data0_d = buf_out;
          last0_d = inflight_last_q;
        end else begin
          data1_d = buf_out;
          last1_d = inflight_last_q;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        data0_d = data1_q;
        last0_d = last1_q;
        occ_d   = occ_q - 2'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q - 7'(rd_en);
    timer_d     = '0;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (enable && (fifo_counter >= BurstLen8)) begin
          rem_d   = BurstLen7;
          state_d = StRead;
        end else if (enable && (TIMEOUT != 0) && (timer_q == TimeoutVal) && !buf_empty) begin
          rem_d   = fifo_counter[6:0];
          state_d = StRead;
        end else if (!buf_empty) begin
          timer_d = (timer_q == TimeoutVal) ? timer_q : timer_q + TW'(1);
        end
      end
      StRead: begin
        if (rem_q == 7'd0) state_d = StDrain;
      end
      StDrain: begin
        if (xfer && m_last) begin
          burst_cnt_d = burst_cnt_q + 16'd1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      rem_q           <= '0;
      timer_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      occ_q           <= '0;
      data0_q         <= '0;
      last0_q         <= 1'b0;
      data1_q         <= '0;
      last1_q         <= 1'b0;
      busy_q          <= 1'b0;
      burst_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      rem_q           <= rem_d;
      timer_q         <= timer_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      occ_q           <= occ_d;
      data0_q         <= data0_d;
      last0_q         <= last0_d;
      data1_q         <= data1_d;
      last1_q         <= last1_d;
      busy_q          <= busy_d;
      burst_cnt_q     <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: a queue-based FIFO model feeds the DUT; a stream monitor checks
// byte order, burst lengths, stall stability and pop legality against a write-order scoreboard.
module tb_fifo_drain_ctrl;

  localparam int unsigned BurstLen = 8;
  localparam int unsigned Timeout  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  buf_out = 8'd0;
  logic        buf_empty = 1'b1;
  logic [7:0]  fifo_counter = 8'd0;
  logic        m_ready = 1'b0;
  logic        rd_en, m_valid, m_last, busy;
  logic [7:0]  m_data;
  logic [15:0] burst_cnt;

  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'd0;

  fifo_drain_ctrl #(
    .BURST_LEN (BurstLen),
    .TIMEOUT   (Timeout)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .buf_out      (buf_out),
    .buf_empty    (buf_empty),
    .fifo_counter (fifo_counter),
    .rd_en        (rd_en),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .busy         (busy),
    .burst_cnt    (burst_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: 64 entries, registered read data; sb records every accepted write in order.
  logic [7:0] fq[$];
  logic [7:0] sb[$];
  int         exp_len[$];

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      sb.delete();
      buf_out <= 8'd0;
    end else begin
      if (rd_en && fq.size() > 0) buf_out <= fq.pop_front();
      if (wr_en && fq.size() < 64) begin
        fq.push_back(wr_data);
        sb.push_back(wr_data);
      end
    end
    buf_empty    <= (rst || fq.size() == 0);
    fifo_counter <= rst ? 8'd0 : 8'(fq.size());
  end

  // Stream monitor.
  int         pops, xfers, cur_len, model_bursts, idle_ne, rd_idx, len_idx;
  logic       mon_xfer;
  logic       prev_stall = 1'b0;
  logic       prev_l;
  logic [7:0] prev_d;

  always @(negedge clk) begin
    if (rst) begin
      pops = 0; xfers = 0; cur_len = 0; model_bursts = 0;
      idle_ne = 0; rd_idx = 0; len_idx = 0; prev_stall = 1'b0;
    end else begin
      mon_xfer = m_valid && m_ready;
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(prev_d));
        check("stall_last", 32'(m_last), 32'(prev_l));
      end
      if (rd_en) begin
        check("rd_nonempty", 32'(buf_empty), 32'd0);
        check("rd_room", 32'((pops - xfers - int'(mon_xfer)) < 2), 32'd1);
      end
      if (!busy && !buf_empty) idle_ne++;
      if (mon_xfer) begin
        if (rd_idx < sb.size()) begin
          check("data", 32'(m_data), 32'(sb[rd_idx]));
          rd_idx++;
        end else begin
          check("data_extra", 32'(rd_idx), 32'(sb.size()));
        end
        cur_len++;
        if (m_last) begin
          check("burst_cnt_at_last", 32'(burst_cnt), 32'(model_bursts));
          if (len_idx < exp_len.size()) begin
            check("burst_len", 32'(cur_len), 32'(exp_len[len_idx]));
            len_idx++;
          end else begin
            check("burst_max", 32'(cur_len <= int'(BurstLen)), 32'd1);
          end
          model_bursts++;
          cur_len = 0;
        end
      end
      pops  += int'(rd_en);
      xfers += int'(mon_xfer);
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_l     = m_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check_state);
    rst = 1'b1; enable = 1'b0; m_ready = 1'b0; wr_en = 1'b0;
    exp_len.delete();
    repeat (2) tick();
    if (check_state) begin
      @(negedge clk);
      check("rst_rd_en", 32'(rd_en), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_last", 32'(m_last), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_burst_cnt", 32'(burst_cnt), 32'd0);
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic push_bytes(input int n, input logic [7:0] base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = rnd ? 8'($urandom) : base + 8'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic run_bursts(input int n, input int budget, input int mode, input string tag);
    logic [3:0] pat;
    pat = 4'b1001;
    for (int i = 0; i < budget && model_bursts < n; i++) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = pat[i[1:0]];
        default: m_ready = ($urandom % 4) != 0;
      endcase
      tick();
    end
    check(tag, 32'(model_bursts), 32'(n));
    check({tag, "_cnt"}, 32'(burst_cnt), 32'(n));
    check({tag, "_lens"}, 32'(len_idx), 32'(exp_len.size()));
  endtask

  initial begin
    int first_v, last_i, k, cnt;

    // Full burst with free-flowing sink.
    do_reset(1'b1);
    push_bytes(8, 8'h10, 1'b0);
    exp_len = '{8};
    m_ready = 1'b1;
    enable  = 1'b1;
    first_v = -1;
    last_i  = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_valid && first_v < 0) first_v = i;
      if (m_valid && m_ready && m_last) begin
        last_i = i;
        break;
      end
    end
    check("full_latency", 32'(first_v >= 0 && first_v <= 3), 32'd1);
    check("full_span", 32'(last_i - first_v), 32'd7);
    @(negedge clk);
    check("full_busy_drop", 32'(busy), 32'd0);
    check("full_cnt", 32'(burst_cnt), 32'd1);
    check("full_lens", 32'(len_idx), 32'd1);

    // Backpressure with ready pattern 1,0,0,1.
    do_reset(1'b0);
    push_bytes(8, 8'h10, 1'b0);
    exp_len = '{8};
    enable  = 1'b1;
    run_bursts(1, 200, 1, "bp");
    check("bp_all_bytes", 32'(rd_idx), 32'(sb.size()));

    // Timeout-forced partial burst.
    do_reset(1'b0);
    enable  = 1'b1;
    m_ready = 1'b1;
    exp_len = '{3};
    push_bytes(3, 8'hA0, 1'b0);
    run_bursts(1, 200, 0, "tmo");
    check("tmo_idle_cycles", 32'(idle_ne), 32'(Timeout + 1));
    check("tmo_fifo_empty", 32'(buf_empty), 32'd1);

    // Back-to-back bursts from 20 queued bytes.
    do_reset(1'b0);
    push_bytes(20, 8'h00, 1'b1);
    exp_len = '{8, 8, 4};
    enable  = 1'b1;
    run_bursts(3, 300, 0, "b2b");

    // Reset one cycle after the third byte transfers.
    do_reset(1'b0);
    push_bytes(8, 8'h30, 1'b0);
    m_ready = 1'b1;
    enable  = 1'b1;
    k = 0;
    for (int i = 0; i < 40 && k < 3; i++) begin
      @(negedge clk);
      if (m_valid && m_ready) k++;
    end
    check("mid_three_xfers", 32'(k), 32'd3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_m_valid", 32'(m_valid), 32'd0);
    check("mid_rd_en", 32'(rd_en), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_burst_cnt", 32'(burst_cnt), 32'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt += int'(m_valid);
    end
    check("mid_no_stale", 32'(cnt), 32'd0);

    // Enable held low, then raised.
    do_reset(1'b0);
    push_bytes(10, 8'h50, 1'b0);
    m_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      cnt += int'(rd_en);
    end
    check("en_low_no_rd", 32'(cnt), 32'd0);
    exp_len = '{8, 2};
    enable  = 1'b1;
    run_bursts(2, 300, 0, "en_high");

    // Randomized traffic, then drain.
    do_reset(1'b0);
    for (int i = 0; i < 1500; i++) begin
      enable  = ($urandom % 8) != 0;
      wr_en   = ($urandom % 3) == 0;
      wr_data = 8'($urandom);
      m_ready = ($urandom % 4) != 0;
      tick();
    end
    wr_en  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 2000 && !(buf_empty && !busy && !m_valid); i++) begin
      m_ready = ($urandom % 4) != 0;
      tick();
    end
    check("rnd_drained", 32'(buf_empty && !busy && !m_valid), 32'd1);
    check("rnd_all_bytes", 32'(rd_idx), 32'(sb.size()));
    check("rnd_cnt", 32'(burst_cnt), 32'(model_bursts));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
